jk_mod_counter: RTL and testbench



---
 rtl/jk_mod_counter_pkg.sv | 22 ++
 rtl/jk_mod_counter_if.sv | 15 +
 rtl/jk_mod_counter_cell.sv | 25 ++
 rtl/jk_mod_counter.sv | 116 +++++++++++
 tb/tb_jk_mod_counter.sv | 139 +++++++++++++
 5 files changed

// File: rtl/jk_mod_counter_pkg.sv
// Shared JK excitation types and helpers for the JK-cell modulo counter.
package jk_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_cmd_t;

  // Never yields TOGGLE: a bit either keeps its value, is set, or is cleared.
  function automatic jk_cmd_t jk_excite(input logic q_bit, input logic next_bit);
    jk_cmd_t cmd;
    case ({next_bit, q_bit})
      2'b10:   cmd = SET;
      2'b01:   cmd = RESET;
      default: cmd = HOLD;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control/status bundle between the issuing controller (master) and the counter (slave).
interface jk_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             dn;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (output en, load, d, dn, input q, tc, ovf);
  modport slave  (input en, load, d, dn, output q, tc, ovf);
endinterface

// File: rtl/jk_mod_counter_cell.sv
// Single JK flip-flop cell with asynchronous active-high clear.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK state update: hold, reset, set or toggle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N counter built from JK cells with load, terminal count and wrap pulse.
// Define JK_MOD_COUNTER_UPDOWN_EN to honour dn (down counting); otherwise up-only.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int          WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic clk,
  input  logic rst,
  jk_mod_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 32'd1);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] up_next_s;
  logic [WIDTH-1:0] count_next_s;
  logic [WIDTH-1:0] load_val_s;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;
  logic             down_s;
  logic             tc_s;
  logic             wrap_s;
  logic             ovf_r;

`ifdef JK_MOD_COUNTER_UPDOWN_EN
  logic [WIDTH-1:0] down_next_s;
  assign down_s      = bus.dn;
  assign down_next_s = (q_s == ZERO_C) ? MAX_C : q_s - ONE_C;
`else
  logic dn_unused_s;
  assign down_s      = 1'b0;
  assign dn_unused_s = bus.dn;
`endif

  // Out-of-range states also wrap to zero when counting up
  assign up_next_s  = (q_s >= MAX_C) ? ZERO_C : q_s + ONE_C;
  assign load_val_s = ({{(32-WIDTH){1'b0}}, bus.d} < 32'(MODULUS)) ? bus.d : MAX_C;

  // Direction select for the counting path and terminal-count compare
  always_comb begin
    count_next_s = up_next_s;
    tc_s         = 1'b0;
`ifdef JK_MOD_COUNTER_UPDOWN_EN
    if (down_s) begin
      count_next_s = down_next_s;
      tc_s         = bus.en & ~bus.load & (q_s == ZERO_C);
    end else begin
      count_next_s = up_next_s;
      tc_s         = bus.en & ~bus.load & (q_s == MAX_C);
    end
`else
    if (down_s) begin
      count_next_s = up_next_s;
      tc_s         = 1'b0;
    end else begin
      count_next_s = up_next_s;
      tc_s         = bus.en & ~bus.load & (q_s == MAX_C);
    end
`endif
  end

  // Requested next count in priority order load > en > hold
  always_comb begin
    next_s = q_s;
    if (bus.load) begin
      next_s = load_val_s;
    end else if (bus.en) begin
      next_s = count_next_s;
    end else begin
      next_s = q_s;
    end
  end

  // Per-bit excitation; hold cycles give next == q and therefore J = K = 0
  always_comb begin
    jk_cmd_t cmd_v;
    j_s = ZERO_C;
    k_s = ZERO_C;
    for (int i = 0; i < WIDTH; i++) begin
      cmd_v  = jk_excite(q_s[i], next_s[i]);
      j_s[i] = cmd_v[1];
      k_s[i] = cmd_v[0];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_s[g]),
      .k   (k_s[g]),
      .q   (q_s[g])
    );
  end

  assign wrap_s = bus.en & ~bus.load & tc_s;

  // One-cycle wrap pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= wrap_s;
    end
  end

  assign bus.q   = q_s;
  assign bus.tc  = tc_s;
  assign bus.ovf = ovf_r;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed-vector bench for jk_mod_counter (WIDTH = 4, MODULUS = 10).
module tb_jk_mod_counter;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  logic toggle_seen;

  jk_mod_counter_if #(.WIDTH(4)) bus ();

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((dut.j_s & dut.k_s) != 4'd0) toggle_seen = 1'b1;
  end

  typedef struct {
    logic       en;
    logic       load;
    logic       dn;
    logic [3:0] d;
    logic       exp_tc;
    logic [3:0] exp_q;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic en, input logic load, input logic dn, input logic [3:0] d);
    bus.en = en; bus.load = load; bus.dn = dn; bus.d = d;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] held;
    n_total = 0; n_pass = 0; toggle_seen = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b1;
    #12;
    check("reset_q", bus.q, 4'd0);
    check("reset_ovf", bus.ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // Up count through one wrap
    for (int k = 0; k < 12; k++)
      vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd0, (k == 9), 4'((k + 1) % 10), (k == 9)});
    // Load clamp and priority over en
    vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd13, 1'b0, 4'd9, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd4,  1'b0, 4'd4, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd10, 1'b0, 4'd9, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd15, 1'b0, 4'd9, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd9,  1'b0, 4'd9, 1'b0});
`ifdef JK_MOD_COUNTER_UPDOWN_EN
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 4'd9, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd8, 1'b0});
`else
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 4'd3, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd4, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd5, 1'b0});
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].load, vecs[i].dn, vecs[i].d);
      #1;
      check($sformatf("vec%0d_tc", i), bus.tc, vecs[i].exp_tc);
      cycle();
      check($sformatf("vec%0d_q", i), bus.q, vecs[i].exp_q);
      check($sformatf("vec%0d_ovf", i), bus.ovf, vecs[i].exp_ovf);
    end

    // Hold: no excitation, count frozen
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    held = bus.q;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("hold_jk", {dut.j_s, dut.k_s}, 8'd0);
      cycle();
      check("hold_q", bus.q, held);
    end

    // Asynchronous reset mid-cycle with q = 7
    drive(1'b0, 1'b1, 1'b0, 4'd7);
    cycle();
    check("pre_rst_q", bus.q, 4'd7);
    drive(1'b1, 1'b1, 1'b0, 4'd5);
    #2 rst = 1'b1;
    #1;
    check("async_rst_q", bus.q, 4'd0);
    check("async_rst_ovf", bus.ovf, 1'b0);
    cycle();
    check("rst_held_q", bus.q, 4'd0);
    rst = 1'b0;

    // Reset right after a wrap clears the pulse immediately
    drive(1'b0, 1'b1, 1'b0, 4'd9);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    cycle();
    check("wrap_ovf", bus.ovf, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_ovf_clear", bus.ovf, 1'b0);
    cycle();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    cycle();
    check("post_rst_count", bus.q, 4'd1);
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    cycle();

    check("no_toggle", toggle_seen, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
